// File: rtl/capture_classifier_pkg.sv
// Shared definitions for the capture classifier: FSM state encoding,
// replay timing constants and the score-minimum helper.
package capture_classifier_pkg;

  // One-hot controller states; any other pattern is treated as illegal
  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    CAPTURE = 6'b000010,
    DUMP    = 6'b000100,
    FILTER  = 6'b001000,
    DRAIN   = 6'b010000,
    REPORT  = 6'b100000
  } state_t;

  // Cycles from presenting a buffer read address to valid read data
  localparam int BUFFER_READ_LATENCY = 2;

  // Idle slots appended to each replay pass so filters see a clear frame gap
  localparam int REPLAY_GAP_CYCLES = 2;

  // Working width of the score-minimum helper; scores are widened to this
  localparam int SCORE_HELPER_WIDTH = 64;

  // Unsigned minimum of two widened scores
  function automatic logic [SCORE_HELPER_WIDTH-1:0] score_min(
    input logic [SCORE_HELPER_WIDTH-1:0] a,
    input logic [SCORE_HELPER_WIDTH-1:0] b
  );
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/capture_classifier_ram.sv
// Capture buffer: true dual-port, read-first, single-clock block RAM.
// HIGH_PERFORMANCE adds an output register, giving two cycles of read latency.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int RAM_WIDTH       = 18,
  parameter int RAM_DEPTH       = 1024,
  parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int ADDR_WIDTH      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]  dina,
  input  logic [RAM_WIDTH-1:0]  dinb,
  input  logic                  clka,
  input  logic                  wea,
  input  logic                  web,
  input  logic                  ena,
  input  logic                  enb,
  input  logic                  rsta,
  input  logic                  rstb,
  input  logic                  regcea,
  input  logic                  regceb,
  output logic [RAM_WIDTH-1:0]  douta,
  output logic [RAM_WIDTH-1:0]  doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  // Both ports read the old contents before any write on the same edge
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data_a <= mem[addra];
    end
    if (enb) begin
      if (web) mem[addrb] <= dinb;
      ram_data_b <= mem[addrb];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_output_reg
    assign douta = ram_data_a;
    assign doutb = ram_data_b;
  end else begin : g_output_reg
    // Output registers; their reset clears only the latch, never the array
    always_ff @(posedge clka) begin
      if (rsta)        douta <= '0;
      else if (regcea) douta <= ram_data_a;
      if (rstb)        doutb <= '0;
      else if (regceb) doutb <= ram_data_b;
    end
  end

endmodule

// File: rtl/capture_classifier.sv
// Capture classifier: records one burst of samples, optionally dumps it as
// bytes, replays it several times to external matched filters, tracks the
// lowest score per channel and reports the best channel against a threshold.
module capture_classifier
  import capture_classifier_pkg::*;
#(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int NUM_CHANNELS      = 2,
  parameter int MATCH_SCORE_WIDTH = 32,
  parameter int NUM_PASSES        = 2 * CAPTURE_LENGTH + 2,
  parameter int DRAIN_CYCLES      = 8,
  localparam int CHANNEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      trigger,
  input  logic                                      dump_en,
  input  logic [MATCH_SCORE_WIDTH-1:0]              threshold,
  input  logic                                      axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0]              axiid,
  output logic                                      filt_axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0]              filt_axiod,
  input  logic [NUM_CHANNELS-1:0]                   score_valid,
  input  logic [NUM_CHANNELS*MATCH_SCORE_WIDTH-1:0] score_data,
  output logic                                      dump_axiov,
  output logic [7:0]                                dump_axiod,
  input  logic                                      dump_axiready,
  output logic                                      busy,
  output logic                                      result_valid,
  output logic                                      result_match,
  output logic [CHANNEL_WIDTH-1:0]                  result_channel,
  output logic [MATCH_SCORE_WIDTH-1:0]              result_score,
  output logic [NUM_CHANNELS-1:0]                   hits
);

  localparam int ADDR_WIDTH  = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
  localparam int PASS_SLOTS  = CAPTURE_LENGTH + REPLAY_GAP_CYCLES;
  localparam int SLOT_WIDTH  = $clog2(PASS_SLOTS + 1);
  localparam int PASS_WIDTH  = $clog2(NUM_PASSES + 1);
  localparam int DRAIN_WIDTH = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPTURE_LENGTH - 1);

  state_t                         state;
  logic                           dump_latched;
  logic [MATCH_SCORE_WIDTH-1:0]   threshold_latched;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [ADDR_WIDTH-1:0]          rd_addr;
  logic                           rd_issue;
  logic                           issue_d1;
  logic                           issue_d2;
  logic [SLOT_WIDTH-1:0]          slot_cnt;
  logic [PASS_WIDTH-1:0]          pass_cnt;
  logic [DRAIN_WIDTH-1:0]         drain_cnt;
  logic [ADDR_WIDTH-1:0]          dump_idx;
  logic [1:0]                     dump_wait;
  logic [SAMPLE_DATA_WIDTH-1:0]   ram_q;
  logic [SAMPLE_DATA_WIDTH-1:0]   port_a_q;
  logic                           buf_we;
  logic [MATCH_SCORE_WIDTH-1:0]   min_r    [NUM_CHANNELS];
  logic [MATCH_SCORE_WIDTH-1:0]   min_next [NUM_CHANNELS];
  logic [MATCH_SCORE_WIDTH-1:0]   best_score;
  logic [CHANNEL_WIDTH-1:0]       best_channel;
  logic [NUM_CHANNELS-1:0]        hit_next;
  logic                           scoring;

  assign buf_we  = (state == CAPTURE) && axiiv;
  assign scoring = (state == CAPTURE) || (state == DUMP) ||
                   (state == FILTER)  || (state == DRAIN);

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH       (SAMPLE_DATA_WIDTH),
    .RAM_DEPTH       (CAPTURE_LENGTH),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_buffer (
    .addra  (wr_addr),
    .addrb  (rd_addr),
    .dina   (axiid),
    .dinb   ('0),
    .clka   (clk),
    .wea    (buf_we),
    .web    (1'b0),
    .ena    (1'b1),
    .enb    (1'b1),
    .rsta   (rst),
    .rstb   (rst),
    .regcea (1'b1),
    .regceb (1'b1),
    .douta  (port_a_q),
    .doutb  (ram_q)
  );

  // Per-channel minimum including any score strobed this cycle
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      min_next[i] = min_r[i];
      if (score_valid[i]) begin
        min_next[i] = MATCH_SCORE_WIDTH'(score_min(
          SCORE_HELPER_WIDTH'(min_r[i]),
          SCORE_HELPER_WIDTH'(score_data[i*MATCH_SCORE_WIDTH +: MATCH_SCORE_WIDTH])));
      end
    end
  end

  // Argmin over channels (strict compare keeps the lowest index on ties) and hit flags
  always_comb begin
    best_score   = min_next[0];
    best_channel = '0;
    hit_next     = '0;
    for (int i = 1; i < NUM_CHANNELS; i++) begin
      if (min_next[i] < best_score) begin
        best_score   = min_next[i];
        best_channel = CHANNEL_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      hit_next[i] = min_next[i] < threshold_latched;
    end
  end

  // Running minimums: reloaded with all-ones on trigger, updated only while a capture is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) min_r[i] <= '1;
    end else if ((state == IDLE) && trigger) begin
      for (int i = 0; i < NUM_CHANNELS; i++) min_r[i] <= '1;
    end else if (scoring) begin
      for (int i = 0; i < NUM_CHANNELS; i++) min_r[i] <= min_next[i];
    end
  end

  // Replay pipeline: delay the issue flag to line up with the two-cycle buffer read
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_d1   <= 1'b0;
      issue_d2   <= 1'b0;
      filt_axiov <= 1'b0;
      filt_axiod <= '0;
    end else begin
      issue_d1   <= rd_issue;
      issue_d2   <= issue_d1;
      filt_axiov <= issue_d2;
      filt_axiod <= issue_d2 ? ram_q : '0;
    end
  end

  // Controller: sequences capture, dump, replay passes, drain and report
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      dump_latched      <= 1'b0;
      threshold_latched <= '0;
      wr_addr           <= '0;
      rd_addr           <= '0;
      rd_issue          <= 1'b0;
      slot_cnt          <= '0;
      pass_cnt          <= '0;
      drain_cnt         <= '0;
      dump_idx          <= '0;
      dump_wait         <= '0;
      dump_axiov        <= 1'b0;
      dump_axiod        <= '0;
      result_valid      <= 1'b0;
      result_match      <= 1'b0;
      result_channel    <= '0;
      result_score      <= '0;
      hits              <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            dump_latched      <= dump_en;
            threshold_latched <= threshold;
            wr_addr           <= '0;
            state             <= CAPTURE;
            busy              <= 1'b1;
          end
        end

        CAPTURE: begin
          if (axiiv) begin
            if (wr_addr == LAST_ADDR) begin
              wr_addr <= '0;
              rd_addr <= '0;
              if (dump_latched) begin
                state     <= DUMP;
                dump_idx  <= '0;
                dump_wait <= '0;
              end else begin
                state    <= FILTER;
                slot_cnt <= '0;
                pass_cnt <= '0;
                rd_issue <= 1'b1;
              end
            end else begin
              wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
          end
        end

        DUMP: begin
          if (dump_axiov) begin
            if (dump_axiready) begin
              dump_axiov <= 1'b0;
              if (dump_idx == LAST_ADDR) begin
                state    <= FILTER;
                slot_cnt <= '0;
                pass_cnt <= '0;
                rd_addr  <= '0;
                rd_issue <= 1'b1;
              end else begin
                dump_idx  <= dump_idx + ADDR_WIDTH'(1);
                rd_addr   <= dump_idx + ADDR_WIDTH'(1);
                dump_wait <= '0;
              end
            end
          end else if (dump_wait == 2'(BUFFER_READ_LATENCY)) begin
            dump_axiov <= 1'b1;
            dump_axiod <= 8'(ram_q);
          end else begin
            dump_wait <= dump_wait + 2'd1;
          end
        end

        FILTER: begin
          if (slot_cnt == SLOT_WIDTH'(PASS_SLOTS - 1)) begin
            slot_cnt <= '0;
            rd_addr  <= '0;
            if (pass_cnt == PASS_WIDTH'(NUM_PASSES - 1)) begin
              state     <= DRAIN;
              pass_cnt  <= '0;
              drain_cnt <= '0;
              rd_issue  <= 1'b0;
            end else begin
              pass_cnt <= pass_cnt + PASS_WIDTH'(1);
              rd_issue <= 1'b1;
            end
          end else begin
            slot_cnt <= slot_cnt + SLOT_WIDTH'(1);
            if (rd_issue && (rd_addr != LAST_ADDR)) begin
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end else begin
              rd_issue <= 1'b0;
              rd_addr  <= '0;
            end
          end
        end

        DRAIN: begin
          if (int'(drain_cnt) + 1 >= DRAIN_CYCLES) begin
            state          <= REPORT;
            drain_cnt      <= '0;
            result_valid   <= 1'b1;
            result_match   <= best_score < threshold_latched;
            result_channel <= best_channel;
            result_score   <= best_score;
            hits           <= hit_next;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_WIDTH'(1);
          end
        end

        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          rd_issue   <= 1'b0;
          dump_axiov <= 1'b0;
          wr_addr    <= '0;
          slot_cnt   <= '0;
          pass_cnt   <= '0;
          drain_cnt  <= '0;
          dump_wait  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/capture_classifier.md
CAPTURE_CLASSIFIER -- requirements
Module: capture_classifier

Interface
Parameters:
REQ-001 The block SHALL have parameter SAMPLE_DATA_WIDTH, default 8, giving the sample width in bits; legal range is 1..8.
REQ-002 The block SHALL have parameter CAPTURE_LENGTH, default 1000, giving the number of samples per capture.
REQ-003 The block SHALL have parameter NUM_CHANNELS, default 2, giving the number of external matched-filter channels; minimum 1.
REQ-004 The block SHALL have parameter MATCH_SCORE_WIDTH, default 32, giving the score width, unsigned.
REQ-005 The block SHALL have parameter NUM_PASSES, default 2*CAPTURE_LENGTH+2, giving the number of replay passes per capture; minimum 1.
REQ-006 The block SHALL have parameter DRAIN_CYCLES, default 8, giving the number of idle cycles after the last pass before scores are judged.

Ports:
REQ-007 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- trigger  in  1  starts a capture; sampled only in IDLE.
- dump_en  in  1  latched at trigger; when set, the buffer is dumped before filtering.
- threshold  in  MATCH_SCORE_WIDTH  match limit, latched at trigger.
- axiiv / axiid  in  1 / SAMPLE_DATA_WIDTH  sample stream.
- filt_axiov  out  1  replay sample valid to all filters.
- filt_axiod  out  SAMPLE_DATA_WIDTH  replay sample.
- score_valid  in  NUM_CHANNELS  per-channel score strobe.
- score_data  in  NUM_CHANNELS*MATCH_SCORE_WIDTH  packed scores; channel i occupies bits [i*W +: W].
- dump_axiov / dump_axiod  out  1 / 8  byte stream, zero-extended sample.
- dump_axiready  in  1  byte sink ready.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  one-cycle pulse at end of classification.
- result_match  out  1  best score < threshold.
- result_channel  out  max(1,$clog2(NUM_CHANNELS))  argmin channel.
- result_score  out  MATCH_SCORE_WIDTH  best score.
- hits  out  NUM_CHANNELS  per-channel minimum < threshold.

Function
REQ-008 The state machine SHALL have the states IDLE, CAPTURE, DUMP, FILTER, DRAIN and REPORT, one-hot encoded; any illegal encoding SHALL return the machine to IDLE.
REQ-009 In IDLE, trigger=1 SHALL latch dump_en and threshold, clear every channel minimum to all-ones, and move to CAPTURE on the next cycle.
REQ-010 In CAPTURE, each axiiv=1 cycle SHALL write axiid at write address 0..CAPTURE_LENGTH-1; after write CAPTURE_LENGTH-1, the machine SHALL go to DUMP if latched dump_en=1, otherwise to FILTER; axiiv outside CAPTURE SHALL be ignored.
REQ-011 DUMP SHALL emit samples 0..CAPTURE_LENGTH-1 in order, one byte per handshake (dump_axiov & dump_axiready); dump_axiod SHALL be held stable while dump_axiov=1 and dump_axiready=0; after the last handshake the machine SHALL go to FILTER.
REQ-012 The capture buffer SHALL have a read latency of 2 cycles; the replay pipeline SHALL compensate for this so that filt_axiod matches filt_axiov.
REQ-013 Each FILTER pass SHALL assert filt_axiov for exactly CAPTURE_LENGTH contiguous cycles carrying samples 0..CAPTURE_LENGTH-1, followed by at least 2 cycles with filt_axiov=0.
REQ-014 After NUM_PASSES passes, the machine SHALL enter DRAIN, wait DRAIN_CYCLES cycles, then enter REPORT.
REQ-015 In CAPTURE, DUMP, FILTER and DRAIN, each cycle with score_valid[i]=1 SHALL update min[i] to min(min[i], score_data channel i); score_valid in IDLE or REPORT SHALL be ignored.
REQ-016 REPORT SHALL last 1 cycle: it SHALL pulse result_valid, select the lowest min (ties go to the lowest index), set result_match = result_score < threshold (unsigned), set hits[i] = min[i] < threshold, and then return to IDLE.
REQ-017 The result_* outputs and hits SHALL hold their values until the next REPORT.
REQ-018 A trigger arriving while busy=1 SHALL be ignored without queuing.
REQ-019 If no score arrives for a channel, min[i] SHALL remain all-ones, and that channel SHALL be a hit only if threshold exceeds all-ones, which is impossible; it is therefore never a hit.

Reset
REQ-020 rst SHALL take priority over every other input in every state, including mid-capture, mid-dump and mid-filter.
REQ-021 On rst, the state SHALL go to IDLE; all counters SHALL be 0; all minimums SHALL be all-ones; and every output SHALL be 0.
REQ-022 Buffer contents SHALL NOT be cleared by rst.

Structure
REQ-023 The state encoding and the score-minimum helper width SHALL reside in the shared package capture_classifier_pkg.
REQ-024 The buffer SHALL be the sole sub-module, instantiated as xilinx_true_dual_port_read_first_1_clock_ram in HIGH_PERFORMANCE mode, with port A used for writes and port B used for reads.

Verification (CAPTURE_LENGTH=8, NUM_CHANNELS=3, NUM_PASSES=2, DRAIN_CYCLES=4)
REQ-025 Scenario capture/replay: trigger, then samples 1..8 with dump_en=0 -> filt_axiod sequence 1..8 twice, each pass 8 contiguous valid cycles separated by gaps of at least 2 cycles.
REQ-026 Scenario classification: threshold=100, with channel scores {500,40,90} followed by {30,60,95} -> result_channel=0, result_score=30, result_match=1, hits=3'b111.
REQ-027 Scenario dump backpressure: dump_en=1 and dump_axiready toggling 1,0,0,1 -> 8 bytes 0x01..0x08 in order with no loss or duplication, and dump_axiod stable while stalled.
REQ-028 Scenario ties and no match: scores {70,70,70} with threshold=70 -> result_channel=0, result_match=0, hits=0.
REQ-029 Scenario reset and re-trigger: rst during FILTER pass 1 -> next cycle busy=0 and filt_axiov=0; trigger pulses during CAPTURE are ignored (only one result_valid pulse).
